// File: rtl/affine_transform_seq_if.sv
// Handshake bundle for affine_transform_seq: operand/matrix/vector in, result out.
// master = upstream/downstream environment side, slave = the affine unit.
interface affine_transform_seq_if #(
   parameter int N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_data;
   logic [N*N-1:0] mat;
   logic [N-1:0]   vec;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_data;

   modport master (
      output in_valid, in_data, mat, vec, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, mat, vec, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/affine_transform_seq.sv
// Iterative GF(2) affine transform out = (T * in) ^ t, R rows per clock.
// Optional completed-transform counter op_count enabled by AFFINE_OP_COUNT_EN.
module affine_transform_seq #(
   parameter int N     = 8,
   parameter int R     = 1,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   affine_transform_seq_if.slave  bus
`ifdef AFFINE_OP_COUNT_EN
   ,
   output logic [CNT_W-1:0]       op_count
`endif
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - R);
   localparam logic [KW-1:0] K_STEP = KW'(R);

   if ((R < 1) || (N % R != 0)) begin : g_bad_r
      $error("affine_transform_seq: R must divide N");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("affine_transform_seq: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t         state;
   state_t         state_n;
   logic [KW-1:0]  k;
   logic [N-1:0]   in_q;
   logic [N*N-1:0] mat_q;
   logic [N-1:0]   vec_q;
   logic [N-1:0]   result;
   logic [R-1:0]   rows;

   // Row i is the parity of (T row i AND operand), flipped by t[i].
   always_comb begin
      rows = '0;
      for (int r = 0; r < R; r++) begin
         rows[r] = (^(mat_q[(int'(k) + r)*N +: N] & in_q)) ^ vec_q[int'(k) + r];
      end
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_n = COMPUTE;
         end
         COMPUTE: begin
            if (k == K_LAST) state_n = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out_data  = result;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         in_q   <= '0;
         mat_q  <= '0;
         vec_q  <= '0;
         result <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  in_q   <= bus.in_data;
                  mat_q  <= bus.mat;
                  vec_q  <= bus.vec;
                  result <= '0;
                  k      <= '0;
               end
            end
            COMPUTE: begin
               result[int'(k) +: R] <= rows;
               // Hold k on the last group so it never runs past N-R.
               if (k != K_LAST) k <= k + K_STEP;
            end
            default: ;
         endcase
      end
   end

`ifdef AFFINE_OP_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if ((state == DONE) && bus.out_ready && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_affine_transform_seq.sv
// Directed, table-driven bench for affine_transform_seq (R=1 and R=2 instances).
// op_count checks are compiled only when AFFINE_OP_COUNT_EN is defined.
module tb_affine_transform_seq;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   affine_transform_seq_if #(.N(8)) bus_a ();
   affine_transform_seq_if #(.N(8)) bus_b ();

`ifdef AFFINE_OP_COUNT_EN
   logic [1:0]  op_count_a;
   logic [15:0] op_count_b;
`endif

   affine_transform_seq #(.N(8), .R(1), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
`ifdef AFFINE_OP_COUNT_EN
      , .op_count(op_count_a)
`endif
   );

   affine_transform_seq #(.N(8), .R(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
`ifdef AFFINE_OP_COUNT_EN
      , .op_count(op_count_b)
`endif
   );

   typedef struct {
      bit          sel;
      logic [63:0] m;
      logic [7:0]  v;
      logic [7:0]  d;
      logic [7:0]  expd;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [63:0] ident();
      logic [63:0] m = '0;
      for (int i = 0; i < 8; i++) m[i*8 + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] rev();
      logic [63:0] m = '0;
      for (int i = 0; i < 8; i++) m[i*8 + (7 - i)] = 1'b1;
      return m;
   endfunction

   function automatic logic rdy(input bit s);
      return s ? bus_b.in_ready : bus_a.in_ready;
   endfunction

   function automatic logic ov(input bit s);
      return s ? bus_b.out_valid : bus_a.out_valid;
   endfunction

   function automatic logic [7:0] od(input bit s);
      return s ? bus_b.out_data : bus_a.out_data;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expd);
      checks++;
      if (act !== expd) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expd);
      end
   endtask

   task automatic drive(input bit s, input logic iv, input logic [63:0] m,
                        input logic [7:0] v, input logic [7:0] d);
      if (s) begin
         bus_b.in_valid = iv; bus_b.mat = m; bus_b.vec = v; bus_b.in_data = d;
      end else begin
         bus_a.in_valid = iv; bus_a.mat = m; bus_a.vec = v; bus_a.in_data = d;
      end
   endtask

   task automatic setOutReady(input bit s, input logic r);
      if (s) bus_b.out_ready = r;
      else   bus_a.out_ready = r;
   endtask

   // Present an operand for the accept edge, then scramble inputs to prove capture.
   task automatic startTxn(input bit s, input logic [63:0] m, input logic [7:0] v, input logic [7:0] d);
      checkOutput("ready before accept", 32'(rdy(s)), 32'd1);
      drive(s, 1'b1, m, v, d);
      @(posedge clk); #1;
      drive(s, 1'b0, ~m, ~v, ~d);
   endtask

   task automatic waitDone(input bit s, output logic [7:0] res, output int edges, output int busy);
      bit done = 0;
      bit partial_ok = 1;
      edges = 1;
      busy  = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         if (ov(s)) begin
            done = 1;
         end else begin
            if (!rdy(s)) busy++;
            if (od(s) !== 8'h00) partial_ok = 0;
            @(posedge clk); #1;
            edges++;
         end
      end
      checkOutput("out_valid within budget", 32'(done), 32'd1);
      checkOutput("out_data zero before done", 32'(partial_ok), 32'd1);
      res = od(s);
   endtask

   task automatic releaseOut(input bit s);
      setOutReady(s, 1'b1);
      @(posedge clk); #1;
      setOutReady(s, 1'b0);
   endtask

   task automatic applyStimulus(input vec_t t, input int idx);
      logic [7:0] res;
      int edges, busy;
      startTxn(t.sel, t.m, t.v, t.d);
      waitDone(t.sel, res, edges, busy);
      checkOutput($sformatf("vec%0d result", idx), 32'(res), 32'(t.expd));
      checkOutput($sformatf("vec%0d latency edges", idx), 32'(edges), t.sel ? 32'd5 : 32'd9);
      checkOutput($sformatf("vec%0d in_ready low cycles", idx), 32'(busy), t.sel ? 32'd4 : 32'd8);
      releaseOut(t.sel);
      checkOutput($sformatf("vec%0d out_valid after release", idx), 32'(ov(t.sel)), 32'd0);
      checkOutput($sformatf("vec%0d in_ready after release", idx), 32'(rdy(t.sel)), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] res;
      int edges, busy;
      bit stable;

      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, '0, '0, '0);
      setOutReady(0, 1'b0);
      setOutReady(1, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(bus_a.in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("reset out_data", 32'(bus_a.out_data), 32'd0);
      checkOutput("reset in_ready R2", 32'(bus_b.in_ready), 32'd1);
      rst = 1'b0;

      tbl[0] = '{0, ident(),              8'h00, 8'hA5, 8'hA5};
      tbl[1] = '{0, ident(),              8'h63, 8'h00, 8'h63};
      tbl[2] = '{0, ident(),              8'h63, 8'hFF, 8'h9C};
      tbl[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h07, 8'hFF};
      tbl[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h03, 8'h00};
      tbl[5] = '{0, rev(),                8'h00, 8'h03, 8'hC0};
      tbl[6] = '{1, ident(),              8'h5A, 8'h0F, 8'h55};

      for (int i = 0; i < 7; i++) applyStimulus(tbl[i], i);

      // Backpressure: result held, new operand waits until IDLE.
      startTxn(0, rev(), 8'h0F, 8'h03);
      waitDone(0, res, edges, busy);
      checkOutput("bp result", 32'(res), 32'hCF);
      drive(0, 1'b1, ident(), 8'h00, 8'h11);
      stable = 1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus_a.out_data !== 8'hCF || bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1)
            stable = 0;
      end
      checkOutput("bp held 20 cycles", 32'(stable), 32'd1);
      releaseOut(0);
      checkOutput("bp out_valid dropped", 32'(bus_a.out_valid), 32'd0);
      checkOutput("bp back in IDLE", 32'(bus_a.in_ready), 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, '0);
      checkOutput("bp next accepted", 32'(bus_a.in_ready), 32'd0);
      waitDone(0, res, edges, busy);
      checkOutput("bp next result", 32'(res), 32'h11);
      checkOutput("bp next latency", 32'(edges), 32'd9);
      releaseOut(0);

      // Reset in the middle of COMPUTE.
      startTxn(0, ident(), 8'h00, 8'h99);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrst in_ready", 32'(bus_a.in_ready), 32'd1);
      checkOutput("midrst out_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("midrst out_data", 32'(bus_a.out_data), 32'd0);
      startTxn(0, ident(), 8'h00, 8'h3C);
      waitDone(0, res, edges, busy);
      checkOutput("midrst new result", 32'(res), 32'h3C);
      checkOutput("midrst new latency", 32'(edges), 32'd9);
      releaseOut(0);

      // Reset together with in_valid: nothing accepted.
      rst = 1'b1;
      drive(0, 1'b1, ident(), 8'h00, 8'h77);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 1'b0, '0, '0, '0);
      checkOutput("rst+valid not accepted", 32'(bus_a.in_ready), 32'd1);
      @(posedge clk); #1;
      checkOutput("rst+valid stays idle", 32'(bus_a.in_ready), 32'd1);
      checkOutput("rst+valid no output", 32'(bus_a.out_valid), 32'd0);

`ifdef AFFINE_OP_COUNT_EN
      begin
         logic [1:0] cnt_exp[5];
         cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         checkOutput("op_count after reset", 32'(op_count_a), 32'd0);
         for (int j = 0; j < 5; j++) begin
            startTxn(0, ident(), 8'h00, 8'(j));
            waitDone(0, res, edges, busy);
            releaseOut(0);
            checkOutput($sformatf("op_count txn%0d", j), 32'(op_count_a), 32'(cnt_exp[j]));
         end
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         checkOutput("op_count cleared", 32'(op_count_a), 32'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
